// File: rtl/fd4_fdm.sv
// FD4/FDM library flop pair for video sync logic.
// FD4 has async clear/preset; FDM is a bare register.
module fd4_fdm #(
  parameter int   WIDTH    = 1,
  parameter logic FDM_INIT = 1'b0
) (
  input  logic             CK,
  input  logic             nRESET,
  input  logic             nSET,
  input  logic [WIDTH-1:0] D4,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] nQ4,
  input  logic [WIDTH-1:0] DM,
  output logic [WIDTH-1:0] QM,
  output logic [WIDTH-1:0] nQM
);

  // Preset is only effective while clear is released, so a
  // clear release with preset still low gives a falling edge
  // here and the flop goes to all-ones without a clock.
  logic             set_act_n;
  logic [WIDTH-1:0] q4_r;
  logic [WIDTH-1:0] qm_r = {WIDTH{FDM_INIT}};

  assign set_act_n = nSET | ~nRESET;

  // FD4: clear beats preset, both beat the clock.
  always_ff @(posedge CK or negedge nRESET or negedge set_act_n) begin
    if (!nRESET) begin
      q4_r <= '0;
    end else if (!set_act_n) begin
      q4_r <= '1;
    end else begin
      q4_r <= D4;
    end
  end

  // FDM: plain capture, power-up value only.
  always_ff @(posedge CK) begin
    qm_r <= DM;
  end

  assign Q4  = q4_r;
  assign nQ4 = ~q4_r;
  assign QM  = qm_r;
  assign nQM = ~qm_r;

endmodule

// File: tb/tb_fd4_fdm.sv
// Bench for fd4_fdm, WIDTH=8, FDM_INIT=1.
// Directed cases then randomized async/capture traffic.
module tb_fd4_fdm;

  localparam int W = 8;

  logic         CK;
  logic         nRESET;
  logic         nSET;
  logic [W-1:0] D4;
  logic [W-1:0] Q4;
  logic [W-1:0] nQ4;
  logic [W-1:0] DM;
  logic [W-1:0] QM;
  logic [W-1:0] nQM;

  logic [W-1:0] e4;
  logic [W-1:0] em;
  int n_vec;
  int n_err;

  fd4_fdm #(
    .WIDTH   (W),
    .FDM_INIT(1'b1)
  ) dut (
    .CK    (CK),
    .nRESET(nRESET),
    .nSET  (nSET),
    .D4    (D4),
    .Q4    (Q4),
    .nQ4   (nQ4),
    .DM    (DM),
    .QM    (QM),
    .nQM   (nQM)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".Q4"}, Q4, e4);
    chk({tag, ".nQ4"}, nQ4, ~e4);
    chk({tag, ".QM"}, QM, em);
    chk({tag, ".nQM"}, nQM, ~em);
  endtask

  // Reference: clear wins, then preset, otherwise hold.
  task automatic async_eval();
    if (!nRESET) e4 = '0;
    else if (!nSET) e4 = '1;
  endtask

  // Drive async pins mid-cycle, then check without a clock.
  task automatic set_async(input logic r, input logic s,
                           input string tag);
    #1;
    nRESET = r;
    nSET = s;
    async_eval();
    #1;
    chk_all(tag);
  endtask

  // One rising edge: FD4 loads only when both async pins high.
  task automatic tick(input string tag);
    @(posedge CK);
    if (nRESET && nSET) e4 = D4;
    em = DM;
    #1;
    chk_all(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nRESET = 1'b1;
    nSET = 1'b1;
    D4 = '1;
    DM = W'($urandom);
    em = '1;
    e4 = '0;

    // power-up: clear asserted, FDM at its init value
    #1;
    nRESET = 1'b0;
    async_eval();
    #1;
    chk_all("pwrup");
    for (int i = 0; i < 3; i++) begin
      DM = W'($urandom);
      tick("pwrup_clk");
    end

    // capture 1,0,1
    set_async(1'b1, 1'b1, "rel");
    D4 = 8'h01; DM = 8'h01; tick("cap1");
    D4 = 8'h00; DM = 8'h00; tick("cap0");
    D4 = 8'h01; DM = 8'h01; tick("cap1b");

    // async preset
    D4 = 8'h00; tick("pre_zero");
    set_async(1'b1, 1'b0, "preset");
    set_async(1'b1, 1'b1, "preset_rel");
    tick("preset_load");

    // clear priority
    set_async(1'b1, 1'b0, "pri_set");
    set_async(1'b0, 1'b0, "pri_both");
    set_async(1'b1, 1'b0, "pri_rel_clr");
    D4 = 8'h00; tick("pri_ign_clk");
    set_async(1'b1, 1'b1, "pri_rel_set");
    D4 = 8'h3C; tick("pri_follow");

    // reset mid-operation
    D4 = 8'hFF; DM = 8'hFF; tick("mid_load");
    set_async(1'b0, 1'b1, "mid_clr");
    DM = 8'h42; tick("mid_fdm");
    set_async(1'b1, 1'b1, "mid_rel");
    D4 = 8'h81; tick("mid_after");

    // full-width pattern
    D4 = 8'hA5; tick("w8_a5");
    set_async(1'b1, 1'b0, "w8_set");
    set_async(1'b1, 1'b1, "w8_rel");

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      D4 = W'($urandom);
      DM = W'($urandom);
      if ($urandom_range(3) == 0)
        set_async(1'($urandom), nSET, "rnd_r");
      if ($urandom_range(3) == 0)
        set_async(nRESET, 1'($urandom), "rnd_s");
      tick("rnd_clk");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
